// File: rtl/codigo_pkg.sv
// codigo_pkg: code digits, sender FSM states and active-low 7-segment patterns shared by the lock and the code sender
package codigo_pkg;
  localparam int N_DIGITOS = 6;
  localparam logic [3:0] CODIGO [0:N_DIGITOS-1] = '{4'd5, 4'd9, 4'd0, 4'd2, 4'd8, 4'd1};
  typedef enum logic [1:0] {OCIOSO, ENVIA, FIM} estado_t;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;
  localparam logic [6:0] SEG [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };
endpackage

// File: rtl/decod_7seg.sv
// decod_7seg: 4-bit digit to active-low segments {A..G}; values above 9 show all segments off
module decod_7seg
  import codigo_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] seg
);
  always_comb seg = digito > 4'd9 ? SEG_APAGADO : SEG[digito];
endmodule

// File: rtl/transmissor_codigo.sv
// transmissor_codigo: sends the lock code 5,9,0,2,8,1 holding each digit DURACAO cycles; DISPLAY_7SEG_EN adds registered segments A..G
module transmissor_codigo
  import codigo_pkg::*;
#(
  parameter int DURACAO = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  output logic [4:1] numero,
  output logic       insere,
  output logic       ocupado,
  output logic       concluido
`ifdef DISPLAY_7SEG_EN
  ,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G
`endif
);
  estado_t estado, estado_prox;
  logic [2:0] idx, idx_prox;
  logic [3:0] cnt, cnt_prox;
  logic fim_digito, ultimo;
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= OCIOSO;
      idx <= 3'd0;
      cnt <= 4'd0;
    end else begin
      estado <= estado_prox;
      idx <= idx_prox;
      cnt <= cnt_prox;
    end
  end
  always_comb begin
    fim_digito = cnt == 4'(DURACAO - 1);
    ultimo = idx == 3'(N_DIGITOS - 1);
    estado_prox = estado == OCIOSO ? (iniciar ? ENVIA : OCIOSO)
                : estado == ENVIA ? (fim_digito && ultimo ? FIM : ENVIA)
                : OCIOSO;
    cnt_prox = estado == ENVIA && !fim_digito ? cnt + 4'd1 : 4'd0;
    idx_prox = estado != ENVIA ? 3'd0 : fim_digito && !ultimo ? idx + 3'd1 : idx;
  end
  always_comb begin
    numero = estado == ENVIA ? CODIGO[idx] : 4'd0;
    insere = estado == ENVIA && cnt == 4'd0;
    ocupado = estado == ENVIA;
    concluido = estado == FIM;
  end
`ifdef DISPLAY_7SEG_EN
  // Decoding the next digit lets the registered segments change together with numero.
  logic [6:0] seg_prox, seg;
  decod_7seg u_decod (
    .digito(estado_prox == ENVIA ? CODIGO[idx_prox] : 4'hF),
    .seg   (seg_prox)
  );
  always_ff @(posedge clk) seg <= reset ? SEG_APAGADO : seg_prox;
  assign {A, B, C, D, E, F, G} = seg;
`endif
endmodule

// File: tb/tb_transmissor_codigo.sv
// tb_transmissor_codigo: checks DURACAO=4 and DURACAO=1 senders against a cycle-age reference model
module tb_transmissor_codigo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0;
  logic [4:1] numero4, numero1;
  logic insere4, ocupado4, concluido4, insere1, ocupado1, concluido1;
  int checks = 0;
  int errors = 0;
  int age4 = -1;
  int age1 = -1;
  int code [6] = '{5, 9, 0, 2, 8, 1};
  always #5 clk = ~clk;
`ifdef DISPLAY_7SEG_EN
  logic sa, sb, sc, sd, se, sf, sg;
  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
`endif
  transmissor_codigo #(.DURACAO(4)) dut4 (
    .clk(clk), .reset(reset), .iniciar(iniciar), .numero(numero4),
    .insere(insere4), .ocupado(ocupado4), .concluido(concluido4)
`ifdef DISPLAY_7SEG_EN
    , .A(sa), .B(sb), .C(sc), .D(sd), .E(se), .F(sf), .G(sg)
`endif
  );
  transmissor_codigo #(.DURACAO(1)) dut1 (
    .clk(clk), .reset(reset), .iniciar(iniciar), .numero(numero1),
    .insere(insere1), .ocupado(ocupado1), .concluido(concluido1)
`ifdef DISPLAY_7SEG_EN
    , .A(), .B(), .C(), .D(), .E(), .F(), .G()
`endif
  );
  function automatic int next_age(int age, int d, logic i, logic r);
    if (r) return -1;
    if (age < 0) return i ? 1 : -1;
    return age == 6 * d + 1 ? -1 : age + 1;
  endfunction
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic chk_dut(string n, int age, int d, logic [3:0] num, logic ins, logic ocu, logic con);
    logic sending;
    sending = age >= 1 && age <= 6 * d;
    chk({n, ".numero"}, int'(num), sending ? code[(age - 1) / d] : 0);
    chk({n, ".insere"}, int'(ins), int'(sending && (age - 1) % d == 0));
    chk({n, ".ocupado"}, int'(ocu), int'(sending));
    chk({n, ".concluido"}, int'(con), int'(age == 6 * d + 1));
  endtask
  task automatic step(logic i, logic r);
    iniciar = i;
    reset = r;
    @(posedge clk);
    age4 = next_age(age4, 4, i, r);
    age1 = next_age(age1, 1, i, r);
    #1;
    chk_dut("d4", age4, 4, numero4, insere4, ocupado4, concluido4);
    chk_dut("d1", age1, 1, numero1, insere1, ocupado1, concluido1);
`ifdef DISPLAY_7SEG_EN
    chk("d4.seg", int'({sa, sb, sc, sd, se, sf, sg}),
        int'(age4 >= 1 && age4 <= 24 ? pat[code[(age4 - 1) / 4]] : 7'b1111111));
`endif
  endtask
  initial begin
    repeat (2) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (9) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (60) step(1'b1, 1'b0);
    repeat (600) step($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/transmissor_codigo.md
TRANSMISSOR_CODIGO -- requirements
Module: transmissor_codigo

Interface
REQ-001 SHALL have parameter: DURACAO, 4, clock cycles each digit is held on numero (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: iniciar  input  1  start request, sampled on each rising edge of clk.
REQ-005 SHALL have port: numero  output  4 ([4:1])  digit currently presented to the lock.
REQ-006 SHALL have port: insere  output  1  one-cycle strobe marking a new digit on numero.
REQ-007 SHALL have port: ocupado  output  1  high while a sequence is being sent.
REQ-008 SHALL have port: concluido  output  1  one-cycle pulse after the last digit's hold ends.
REQ-009 SHALL have ports, only when DISPLAY_7SEG_EN is defined: A, B, C, D, E, F, G  output  1 each  active-low segments showing numero.

Function
REQ-010 SHALL send the fixed 6-digit code 5, 9, 0, 2, 8, 1 in that order on numero.
REQ-011 SHALL implement the states OCIOSO, ENVIA and FIM, with transitions OCIOSO->ENVIA on iniciar=1, ENVIA->FIM after the 6th digit's hold, and FIM->OCIOSO unconditionally after one cycle.
REQ-012 SHALL, when iniciar=1 is sampled in OCIOSO at edge k, drive numero=5 and insere=1 and ocupado=1 in the cycle following edge k.
REQ-013 SHALL hold each digit on numero for exactly DURACAO cycles, assert insere only in the first of those cycles, and present the next digit in the cycle immediately after.
REQ-014 SHALL, with DURACAO=1, assert insere in 6 consecutive cycles with a new digit in each.
REQ-015 SHALL track position with a 3-bit digit index (0..5) and a 4-bit hold counter; the index SHALL NOT wrap past 5.
REQ-016 SHALL assert concluido=1 and ocupado=0 for exactly the one FIM cycle, which is 6*DURACAO+1 cycles after the sampling edge of iniciar.
REQ-017 SHALL drive numero=0000 and insere=0 in OCIOSO and FIM.
REQ-018 SHALL ignore iniciar while in ENVIA or FIM; a held-high iniciar SHALL start a new sequence from OCIOSO on the next edge.

Reset
REQ-019 SHALL, on reset=1 at a clock edge, enter OCIOSO with numero=0000, insere=0, ocupado=0, concluido=0, digit index=0 and hold counter=0.
REQ-020 SHALL, on reset asserted mid-sequence, abort the sequence with no concluido pulse.
REQ-021 SHALL give reset priority over iniciar when both are high at the same edge.

Configuration
REQ-022 SHALL, when DISPLAY_7SEG_EN is defined, decode numero to segments A..G, active-low, standard 0..9 patterns, and show all segments off (all 1) in OCIOSO and FIM.
REQ-023 SHALL, when DISPLAY_7SEG_EN is defined, register the segment outputs so that they change in the same cycle as numero.
REQ-024 SHALL, when DISPLAY_7SEG_EN is undefined, omit ports A..G and the decoder entirely.

Structure
REQ-025 SHALL keep the following in a shared package codigo_pkg, for use by the lock and this block: the 6-entry code constant, state encodings, and the segment pattern constants for 0..9 and blank.
REQ-026 SHALL place the decoder in one sub-module, decod_7seg (4-bit in, 7 active-low out), instantiated only under DISPLAY_7SEG_EN.

Verification
REQ-027 SHALL cover: DURACAO=4, iniciar pulsed one cycle -> insere high at cycles 1, 5, 9, 13, 17, 21 with numero 5, 9, 0, 2, 8, 1; concluido at cycle 25.
REQ-028 SHALL cover: DURACAO=1 -> insere high for cycles 1..6 with numero 5, 9, 0, 2, 8, 1; concluido at cycle 7.
REQ-029 SHALL cover: iniciar re-pulsed at cycle 10 of a DURACAO=4 run -> sequence unchanged; concluido still at cycle 25.
REQ-030 SHALL cover: reset at cycle 7 of a DURACAO=4 run -> next cycle numero=0, ocupado=0; no concluido within the following 30 cycles.
REQ-031 SHALL cover: transmissor_codigo connected to the lock receiver -> after the 6th strobe the lock reaches its code-accepted state with the error LED off.
REQ-032 SHALL cover, with DISPLAY_7SEG_EN defined: numero=5 -> A..G=0100100; numero=1 -> 1001111; idle -> 1111111.
